// File: rtl/sensor_frame_sched_if.sv
// -----------------------------------------------------------------------------
// sensor_frame_sched_if
// Bundles every non-clock/reset signal of the acquisition scheduler.
//   slave  : scheduler side (drives SPI/UART requests and status)
//   master : environment side (enable, SPI/UART responses)
// Signals:
//   enable        run scheduler
//   spi_start     one-cycle SPI read request      (slave -> master)
//   spi_done      one-cycle read complete         (master -> slave)
//   spi_rx_data   sensor word, valid with spi_done
//   uart_tx_busy  UART transmitter busy
//   uart_tx_start one-cycle transmit request      (slave -> master)
//   uart_tx_data  byte to transmit
//   uart_tx_done  one-cycle byte finished
//   sample_out    last captured sample
//   sample_valid  one-cycle pulse when sample_out updates
//   err_timeout   sticky SPI timeout flag
//   err_overrun   sticky period overrun flag
//   busy          scheduler is mid-acquisition
// -----------------------------------------------------------------------------
interface sensor_frame_sched_if #(
    parameter int DATA_W = 16
);
    logic              enable;
    logic              spi_start;
    logic              spi_done;
    logic [DATA_W-1:0] spi_rx_data;
    logic              uart_tx_busy;
    logic              uart_tx_start;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_done;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              err_timeout;
    logic              err_overrun;
    logic              busy;

    modport slave (
        input  enable, spi_done, spi_rx_data, uart_tx_busy, uart_tx_done,
        output spi_start, uart_tx_start, uart_tx_data, sample_out,
               sample_valid, err_timeout, err_overrun, busy
    );

    modport master (
        output enable, spi_done, spi_rx_data, uart_tx_busy, uart_tx_done,
        input  spi_start, uart_tx_start, uart_tx_data, sample_out,
               sample_valid, err_timeout, err_overrun, busy
    );
endinterface

// File: rtl/sensor_frame_sched.sv
// -----------------------------------------------------------------------------
// sensor_frame_sched
// Periodic acquisition scheduler: once per TICK_CYCLES it requests one SPI
// sensor read, captures the word and sends a 4-byte frame
// (A5, sample[15:8], sample[7:0], xor-checksum) through the UART one byte at
// a time. Flags SPI timeouts and ticks that land while a frame is in flight.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   sensor_frame_sched_if.slave (SPI/UART handshakes, sample, status)
// -----------------------------------------------------------------------------
module sensor_frame_sched #(
    parameter int TICK_CYCLES = 10_000_000,  // >= 16
    parameter int SPI_TIMEOUT = 1024,        // >= 2
    parameter int DATA_W      = 16           // frame format assumes 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_frame_sched_if.slave  bus
);
    localparam int TMR_W = $clog2(TICK_CYCLES);
    localparam int TO_W  = $clog2(SPI_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_SPI_REQ, S_SPI_WAIT,
        S_UART_REQ, S_UART_START, S_UART_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [TMR_W-1:0]  r_timer;
    logic [TO_W-1:0]   r_to_cnt;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_sample;
    logic              r_sample_valid;
    logic [7:0]        r_tx_data;
    logic              r_err_timeout;
    logic              r_err_overrun;
    logic              w_tick;
    logic              w_to_hit;
    logic              w_spi_start;
    logic              w_tx_start;
    logic              w_in_frame;

    // Frame byte idx of a captured sample; byte 3 is the xor of bytes 0..2.
    function automatic logic [7:0] f_frame_byte(input logic [DATA_W-1:0] s,
                                                input logic [1:0]        idx);
        case (idx)
            2'd0:    f_frame_byte = 8'hA5;
            2'd1:    f_frame_byte = s[15:8];
            2'd2:    f_frame_byte = s[7:0];
            default: f_frame_byte = 8'hA5 ^ s[15:8] ^ s[7:0];
        endcase
    endfunction

    assign w_tick = bus.enable && (r_timer == TMR_W'(TICK_CYCLES - 1));

    // r_to_cnt is 0 in the first SPI_WAIT cycle, i.e. it lags the cycles since
    // spi_start by one. Firing at SPI_TIMEOUT-2 makes the abort take effect
    // exactly SPI_TIMEOUT cycles after spi_start.
    assign w_to_hit = (r_to_cnt == TO_W'(SPI_TIMEOUT - 2));

    // Period timer: free-running while enabled, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst || !bus.enable || w_tick) r_timer <= '0;
        else                              r_timer <= r_timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:       if (bus.enable) w_next = S_WAIT_TICK;
            S_WAIT_TICK:  if (!bus.enable) w_next = S_IDLE;
                          else if (w_tick) w_next = S_SPI_REQ;
            S_SPI_REQ:    w_next = S_SPI_WAIT;
            // A done coinciding with the timeout wins.
            S_SPI_WAIT:   if (bus.spi_done) w_next = S_UART_REQ;
                          else if (w_to_hit) w_next = bus.enable ? S_WAIT_TICK : S_IDLE;
            S_UART_REQ:   if (!bus.uart_tx_busy) w_next = S_UART_START;
            S_UART_START: w_next = S_UART_WAIT;
            S_UART_WAIT:  if (bus.uart_tx_done) begin
                              if (r_idx == 2'd3) w_next = bus.enable ? S_WAIT_TICK : S_IDLE;
                              else               w_next = S_UART_REQ;
                          end
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_spi_start = (r_state == S_SPI_REQ);
        w_tx_start  = (r_state == S_UART_START);
        w_in_frame  = (r_state != S_IDLE) && (r_state != S_WAIT_TICK);
    end

    // Datapath and sticky flags. uart_tx_data is loaded with the next byte
    // before UART_REQ is entered, so it is stable for the whole handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt       <= '0;
            r_idx          <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_tx_data      <= 8'h00;
            r_err_timeout  <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                S_SPI_REQ: r_to_cnt <= '0;
                S_SPI_WAIT: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (bus.spi_done) begin
                        r_sample       <= bus.spi_rx_data;
                        r_sample_valid <= 1'b1;
                        r_idx          <= 2'd0;
                        r_tx_data      <= f_frame_byte(bus.spi_rx_data, 2'd0);
                    end else if (w_to_hit) begin
                        r_err_timeout  <= 1'b1;
                    end
                end
                S_UART_WAIT: begin
                    if (bus.uart_tx_done && (r_idx != 2'd3)) begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= f_frame_byte(r_sample, r_idx + 2'd1);
                    end
                end
                default: ;
            endcase
            // A tick during an acquisition is dropped, only flagged.
            if (w_tick && w_in_frame) r_err_overrun <= 1'b1;
        end
    end

    assign bus.spi_start     = w_spi_start;
    assign bus.uart_tx_start = w_tx_start;
    assign bus.busy          = w_in_frame;
    assign bus.uart_tx_data  = r_tx_data;
    assign bus.sample_out    = r_sample;
    assign bus.sample_valid  = r_sample_valid;
    assign bus.err_timeout   = r_err_timeout;
    assign bus.err_overrun   = r_err_overrun;
endmodule
